// File: rtl/policy_lookup.sv
// PBVI runtime policy query: stores one alpha vector + action per belief point and
// scans all slots one per cycle to return the vector with the largest dot product.
module policy_lookup #(
  parameter int unsigned N_ENTRY = 16,
  parameter int unsigned W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [$clog2(N_ENTRY)-1:0]   wr_idx,
  input  logic [W-1:0]                 wr_alpha0,
  input  logic [W-1:0]                 wr_alpha1,
  input  logic [1:0]                   wr_action,
  input  logic                         q_valid,
  output logic                         q_ready,
  input  logic [W-1:0]                 q_belief0,
  input  logic [W-1:0]                 q_belief1,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic                         r_hit,
  output logic [$clog2(N_ENTRY)-1:0]   r_idx,
  output logic [1:0]                   r_action,
  output logic [2*W:0]                 r_value
);

  localparam int unsigned IW = $clog2(N_ENTRY);
  localparam int unsigned PW = 2 * W;
  localparam int unsigned VW = 2 * W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [W-1:0]        r_a0  [N_ENTRY];
  logic [W-1:0]        r_a1  [N_ENTRY];
  logic [1:0]          r_act [N_ENTRY];
  logic [N_ENTRY-1:0]  r_vld;

  logic [W-1:0]        r_b0;
  logic [W-1:0]        r_b1;
  logic [IW-1:0]       r_scan_idx;

  logic [PW-1:0]       w_p0;
  logic [PW-1:0]       w_p1;
  logic [VW-1:0]       w_val;
  logic                w_upd;

  // Slot valid bits; clr dominates a same-cycle write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (clr) begin
      r_vld <= '0;
    end else if (wr_en) begin
      r_vld[wr_idx] <= 1'b1;
    end
  end

  // Slot payload; left untouched by clr so only the valid bit gates it
  always_ff @(posedge clk) begin
    if (rst_n && !clr && wr_en) begin
      r_a0[wr_idx]  <= wr_alpha0;
      r_a1[wr_idx]  <= wr_alpha1;
      r_act[wr_idx] <= wr_action;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (q_valid) w_next = S_SCAN;
      S_SCAN:  if (r_scan_idx == IW'(N_ENTRY - 1)) w_next = S_RESP;
      S_RESP:  if (r_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Dot product of the slot under evaluation; 2W+1 bits cannot overflow
  always_comb begin
    w_p0  = PW'(r_b0) * PW'(r_a0[r_scan_idx]);
    w_p1  = PW'(r_b1) * PW'(r_a1[r_scan_idx]);
    w_val = VW'(w_p0) + VW'(w_p1);
    w_upd = r_vld[r_scan_idx] && (!r_hit || (w_val > r_value));
  end

  // Running best doubles as the result register; strict > keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_hit      <= 1'b0;
      r_idx      <= '0;
      r_action   <= '0;
      r_value    <= '0;
      r_scan_idx <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
    end else begin
      q_ready <= (w_next == S_IDLE);
      r_valid <= (w_next == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (q_valid) begin
            r_b0       <= q_belief0;
            r_b1       <= q_belief1;
            r_scan_idx <= '0;
            r_hit      <= 1'b0;
            r_idx      <= '0;
            r_action   <= '0;
            r_value    <= '0;
          end
        end
        S_SCAN: begin
          r_scan_idx <= r_scan_idx + IW'(1);
          if (w_upd) begin
            r_hit    <= 1'b1;
            r_idx    <= r_scan_idx;
            r_action <= r_act[r_scan_idx];
            r_value  <= w_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_policy_lookup.sv
// Randomized + directed bench for policy_lookup with a queue scoreboard and an
// argmax reference model over a shadow copy of the slot table.
module tb_policy_lookup;

  logic        clk = 1'b0;
  logic        rst_n, clr, wr_en;
  logic [3:0]  wr_idx;
  logic [15:0] wr_alpha0, wr_alpha1;
  logic [1:0]  wr_action;
  logic        q_valid, q_ready;
  logic [15:0] q_belief0, q_belief1;
  logic        r_valid, r_ready, r_hit;
  logic [3:0]  r_idx;
  logic [1:0]  r_action;
  logic [32:0] r_value;

  policy_lookup dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_alpha0(wr_alpha0), .wr_alpha1(wr_alpha1), .wr_action(wr_action),
    .q_valid(q_valid), .q_ready(q_ready), .q_belief0(q_belief0), .q_belief1(q_belief1),
    .r_valid(r_valid), .r_ready(r_ready), .r_hit(r_hit), .r_idx(r_idx),
    .r_action(r_action), .r_value(r_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [3:0]  idx;
    logic [1:0]  act;
    logic [32:0] val;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  bit          seen_rise = 0;
  bit          rnd_ready = 0;

  logic [15:0] m_a0  [16];
  logic [15:0] m_a1  [16];
  logic [1:0]  m_act [16];
  bit          m_vld [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: find the maximum value over valid slots, then the first slot holding it
  function automatic exp_t model(input logic [15:0] b0, input logic [15:0] b1, input int acc);
    exp_t e;
    longint unsigned v [16];
    longint unsigned maxv = 0;
    bit any = 0;
    e.hit = 0; e.idx = 0; e.act = 0; e.val = 0; e.acc = acc;
    for (int i = 0; i < 16; i++) begin
      v[i] = longint'(b0) * longint'(m_a0[i]) + longint'(b1) * longint'(m_a1[i]);
      if (m_vld[i] && (!any || v[i] > maxv)) begin
        maxv = v[i];
        any  = 1;
      end
    end
    for (int i = 15; i >= 0; i--) begin
      if (m_vld[i] && v[i] == maxv) begin
        e.hit = 1; e.idx = 4'(i); e.act = m_act[i]; e.val = 33'(maxv);
      end
    end
    return e;
  endfunction

  // Monitor: compare on every accepted result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      seen_rise = 0;
    end else begin
      if (r_valid === 1'b1 && !seen_rise) begin
        rise_cyc  = cyc;
        seen_rise = 1;
      end
      if (r_valid === 1'b1 && r_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("r_hit", 64'(r_hit), 64'(e.hit));
          chk("r_idx", 64'(r_idx), 64'(e.idx));
          chk("r_action", 64'(r_action), 64'(e.act));
          chk("r_value", 64'(r_value), 64'(e.val));
          chk("latency", 64'(rise_cyc - e.acc), 64'd16);
        end
        seen_rise = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) r_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic wr(input int idx, input logic [15:0] a0, input logic [15:0] a1,
                    input logic [1:0] act, input bit with_clr);
    wr_en = 1; clr = with_clr; wr_idx = 4'(idx);
    wr_alpha0 = a0; wr_alpha1 = a1; wr_action = act;
    @(posedge clk); #1;
    wr_en = 0; clr = 0;
    if (with_clr) begin
      for (int i = 0; i < 16; i++) m_vld[i] = 0;
    end else begin
      m_vld[idx] = 1; m_a0[idx] = a0; m_a1[idx] = a1; m_act[idx] = act;
    end
  endtask

  task automatic do_clr();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    for (int i = 0; i < 16; i++) m_vld[i] = 0;
  endtask

  task automatic do_query(input logic [15:0] b0, input logic [15:0] b1, input bit push,
                          output int acc);
    int n = 0;
    q_belief0 = b0; q_belief1 = b1; q_valid = 1;
    @(negedge clk);
    while (q_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q_ready !== 1'b1) chk("q_ready_timeout", 64'(q_ready), 64'd1);
    acc = cyc + 1;
    if (push) sb.push_back(model(b0, b1, acc));
    @(posedge clk); #1;
    q_valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || r_valid === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, r_edge, n, cnt;
    rst_n = 0; clr = 0; wr_en = 0; wr_idx = 0; wr_alpha0 = 0; wr_alpha1 = 0;
    wr_action = 0; q_valid = 0; q_belief0 = 0; q_belief1 = 0; r_ready = 1;
    for (int i = 0; i < 16; i++) begin
      m_vld[i] = 0; m_a0[i] = 0; m_a1[i] = 0; m_act[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_ready", 64'(q_ready), 64'd1);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_r_hit", 64'(r_hit), 64'd0);
    chk("rst_r_idx", 64'(r_idx), 64'd0);
    chk("rst_r_action", 64'(r_action), 64'd0);
    chk("rst_r_value", 64'(r_value), 64'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // Empty table
    do_query(16'd100, 16'd200, 1, acc);
    wait_done();

    // Basic argmax
    wr(3, 16'd10, 16'd20, 2'd2, 0);
    wr(9, 16'd30, 16'd5, 2'd1, 0);
    do_query(16'd1, 16'd1, 1, acc);
    wait_done();

    // Tie keeps lowest index
    do_clr();
    wr(2, 16'd5, 16'd5, 2'd3, 0);
    wr(7, 16'd5, 16'd5, 2'd1, 0);
    do_query(16'd2, 16'd2, 1, acc);
    wait_done();

    // Full-width product sum
    do_clr();
    wr(0, 16'hFFFF, 16'hFFFF, 2'd2, 0);
    do_query(16'hFFFF, 16'hFFFF, 1, acc);
    wait_done();

    // Stall in RESP, then back-to-back query
    wr(5, 16'd900, 16'd1, 2'd3, 0);
    r_ready = 0;
    do_query(16'd3, 16'd7, 1, acc);
    n = 0;
    @(negedge clk);
    while (r_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("stall_r_valid_seen", 64'(r_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_r_valid", 64'(r_valid), 64'd1);
      chk("stall_q_ready", 64'(q_ready), 64'd0);
      chk("stall_r_value", 64'(r_value), 64'(sb[0].val));
      chk("stall_r_idx", 64'(r_idx), 64'(sb[0].idx));
    end
    @(posedge clk); #1;
    r_ready = 1;
    r_edge = cyc + 1;
    do_query(16'd8, 16'd2, 1, acc);
    chk("b2b_accept_cycle", 64'(acc), 64'(r_edge + 1));
    wait_done();

    // clr beats a same-cycle write
    do_clr();
    wr(4, 16'd50, 16'd60, 2'd1, 1);
    do_query(16'd9, 16'd9, 1, acc);
    wait_done();

    // Reset mid-scan aborts the query
    wr(1, 16'd4, 16'd4, 2'd2, 0);
    do_query(16'd5, 16'd5, 0, acc);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 16; i++) m_vld[i] = 0;
    @(negedge clk);
    chk("post_rst_q_ready", 64'(q_ready), 64'd1);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (r_valid !== 1'b0) cnt++;
    end
    chk("no_result_after_reset", 64'(cnt), 64'd0);
    @(posedge clk); #1;

    // Random writes, clears and queries with random result back-pressure
    rnd_ready = 1;
    for (int t = 0; t < 30; t++) begin
      int nw = $urandom_range(0, 3);
      logic [15:0] v0, v1;
      if ($urandom_range(0, 9) == 0) do_clr();
      for (int w = 0; w < nw; w++) begin
        case ($urandom_range(0, 2))
          0: begin v0 = 16'($urandom_range(0, 7)); v1 = 16'($urandom_range(0, 7)); end
          1: begin v0 = 16'($urandom); v1 = 16'($urandom); end
          default: begin v0 = 16'hFFFF; v1 = 16'($urandom_range(0, 1) * 16'hFFFF); end
        endcase
        wr($urandom_range(0, 15), v0, v1, 2'($urandom_range(0, 3)), 0);
      end
      if ($urandom_range(0, 1) == 0) begin
        v0 = 16'($urandom_range(0, 3)); v1 = 16'($urandom_range(0, 3));
      end else begin
        v0 = 16'($urandom); v1 = 16'($urandom);
      end
      do_query(v0, v1, 1, acc);
      wait_done();
    end
    rnd_ready = 0;
    #2;
    r_ready = 1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/policy_lookup.md
# policy_lookup

Online policy-query engine for the PBVI flow. It holds the alpha-vector set written by the per-point action-selection stage: one alpha vector (two components) plus its action per belief point. For a query belief it scans the stored vectors one per cycle and returns the action, index and value of the vector with the largest dot product. It sits after the offline backup/selection stages and serves the runtime controller.

## Interface
- N_ENTRY, 16: number of alpha-vector slots; index width is 4 bits.
- W, 16: width of belief components and alpha components (unsigned).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous and active-low, sampled on the rising edge of clk.
- clr  in  1  invalidate all slots.
- wr_en  in  1  write one slot this cycle.
- wr_idx  in  4  slot to write.
- wr_alpha0, wr_alpha1  in  W each  alpha components for state 0 / 1.
- wr_action  in  2  action tag stored with the slot.
- q_valid  in  1  query belief present.
- q_ready  out  1  engine can accept a query.
- q_belief0, q_belief1  in  W each  query belief components.
- r_valid  out  1  result available.
- r_ready  in  1  consumer accepts result.
- r_hit  out  1  at least one valid slot was found during the scan.
- r_idx  out  4  winning slot.
- r_action  out  2  winning slot's action.
- r_value  out  2W+1  winning dot product.

## Operation
- Storage: N_ENTRY slots of {alpha0, alpha1, action, valid}.
  - wr_en writes the slot and sets its valid bit at the edge.
  - clr clears every valid bit at the edge. Slot data is left unchanged.
  - clr and wr_en in the same cycle: clr wins and the write is dropped.
  - Writes are accepted in every FSM state.
- FSM states: IDLE, SCAN, RESP.
  - IDLE: q_ready=1. On q_valid&&q_ready, latch both belief components, set idx=0, clear found, go to SCAN.
  - SCAN: each cycle evaluate slot idx: val = b0*a0 + b1*a1.
    - Products are unsigned W×W→2W. The sum is 2W+1 bits, so there is no overflow.
    - Update best {val, idx, action} when the slot is valid and either found==0 or val > best_val (strict). Ties therefore keep the lowest index.
    - Set found on any valid slot.
    - idx increments. After evaluating idx=N_ENTRY-1, go to RESP.
  - RESP: r_valid=1. Outputs hold stable until r_valid&&r_ready, then go to IDLE.
- If no slot is valid: r_hit=0, r_idx=0, r_action=0, r_value=0.
- SCAN reads slot contents as they stand in the evaluation cycle. A write landing at the same edge is not seen for that slot, and later slots see new data.
- A clr during SCAN affects only slots not yet evaluated.

## Timing
- Reset (rst_n low at an edge): state=IDLE, all valid bits=0, r_valid=0, r_hit=0, r_idx=0, r_action=0, r_value=0, internal best/idx cleared. q_ready is 1 from the first cycle after the reset edge.
- Reset mid-SCAN or mid-RESP aborts the query. No result is produced, and a held r_valid drops at the reset edge.
- q_ready = (state==IDLE), decoded from registered state. It is 0 during SCAN and RESP, so q_valid is back-pressured and one query is in flight at a time.
- Latency: query accepted at edge T; slot k evaluated in the cycle after edge T+k; r_valid=1 after edge T+N_ENTRY (16 cycles).
- r_valid&&r_ready at edge R returns to IDLE. q_ready=1 after R, so the next query is accepted at R+1 at the earliest.
- Throughput: one query per N_ENTRY+2 cycles with r_ready held high.
- All outputs are registered or state-decoded, with no combinational path from inputs to outputs.

## Test plan
- Reset, then query b=(100,200) with no writes: r_valid 16 cycles after acceptance, r_hit=0, r_idx=0, r_action=0, r_value=0.
- Write slot 3 = (10,20, act 2) and slot 9 = (30,5, act 1); query b=(1,1): slot 3 gives 30, slot 9 gives 35 → r_idx=9, r_action=1, r_value=35.
- Tie case: slots 2 and 7 both (5,5); query b=(2,2): result r_idx=2, value 20.
- Width check: slot 0 = (0xFFFF,0xFFFF); query b=(0xFFFF,0xFFFF): r_value=0x1FFFC0002, no truncation.
- Handshake: hold r_ready=0 for 5 cycles in RESP: outputs stable and q_ready=0 throughout. Raise r_ready: IDLE next cycle, and a back-to-back query is accepted.
- clr and wr_en to slot 4 in the same cycle: slot 4 stays invalid, and a subsequent query with only slot 4 written that way returns r_hit=0. Separately, assert rst_n low mid-SCAN: r_valid never asserts, q_ready=1 after reset.
